// File: rtl/finger_key_locator_pkg.sv
// Shared definitions for the finger_key_locator block: FSM encoding, coordinate
// width and the default camera geometry used by the capture and yuv2rgb stages.
package finger_key_locator_pkg;

  localparam int COORD_W = 11;

  localparam int DEFAULT_IMG_W = 640;
  localparam int DEFAULT_IMG_H = 480;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_ACCUM      = 2'd1,
    ST_EVAL       = 2'd2
  } state_t;

endpackage

// File: rtl/finger_key_locator_key_debouncer.sv
// One key's debounce: the stable bit flips only after DEBOUNCE consecutive
// evaluated frames disagree with it; any agreeing frame restarts the count.
module finger_key_locator_key_debouncer #(
  parameter int DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic eval_en,
  input  logic hit,
  output logic key_bit
);

  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [DEB_W-1:0] deb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb     <= '0;
      key_bit <= 1'b0;
    end else if (eval_en) begin
      if (hit == key_bit) begin
        deb <= '0;
      end else if (deb == DEB_LAST) begin
        key_bit <= ~key_bit;
        deb     <= '0;
      end else begin
        deb <= deb + 1'b1;
      end
    end
  end

endmodule

// File: rtl/finger_key_locator.sv
// Counts finger pixels per key zone inside a row band, snapshots the counts at
// each frame boundary, then thresholds and debounces them into key_mask.
module finger_key_locator
  import finger_key_locator_pkg::*;
#(
  parameter int IMG_W        = DEFAULT_IMG_W,
  parameter int NUM_KEYS     = 16,
  parameter int KEY_W        = 40,
  parameter int ROW_LO       = 200,
  parameter int ROW_HI       = 279,
  parameter int CNT_W        = 12,
  parameter int PRESS_THRESH = 64,
  parameter int DEBOUNCE     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                pix_valid,
  input  logic                line_end,
  input  logic                is_finger,
  output logic [NUM_KEYS-1:0] key_mask,
  output logic                mask_valid,
  output logic [31:0]         debug_out
);

  localparam int ZONE_W = $clog2(NUM_KEYS + 1);
  localparam int KW_W   = $clog2(KEY_W + 1);
  localparam int MW     = (NUM_KEYS < 16) ? NUM_KEYS : 16;

  localparam logic [COORD_W-1:0] X_MAX        = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] Y_LO         = COORD_W'(ROW_LO);
  localparam logic [COORD_W-1:0] Y_HI         = COORD_W'(ROW_HI);
  localparam logic [ZONE_W-1:0]  ZONE_END     = ZONE_W'(NUM_KEYS);
  localparam logic [KW_W-1:0]    IN_ZONE_LAST = KW_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0]   THRESH       = CNT_W'(PRESS_THRESH);

  state_t             state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [ZONE_W-1:0]  zone;
  logic [KW_W-1:0]    in_zone;
  logic [CNT_W-1:0]   cnt  [NUM_KEYS];
  logic [CNT_W-1:0]   snap [NUM_KEYS];
  logic [15:0]        frame_cnt;

  logic               count_en;
  logic               eval_en;
  logic [NUM_KEYS-1:0] hit;

  // pix_valid is a pure qualifier: the upstream stage never stalls and this
  // block has no ready, so every pix_valid cycle is exactly one pixel.
  // zone == ZONE_END means x has moved past the last key zone.
  assign count_en = pix_valid && is_finger && (zone != ZONE_END) &&
                    (y >= Y_LO) && (y <= Y_HI);
  assign eval_en  = (state == ST_EVAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAIT_FRAME;
      x          <= '0;
      y          <= '0;
      zone       <= '0;
      in_zone    <= '0;
      frame_cnt  <= '0;
      mask_valid <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        cnt[k]  <= '0;
        snap[k] <= '0;
      end
    end else begin
      mask_valid <= 1'b0;
      if (state == ST_EVAL) begin
        mask_valid <= 1'b1;
        frame_cnt  <= frame_cnt + 1'b1;
      end

      if (frame_start) begin
        // A pixel arriving with frame_start belongs to neither frame.
        x       <= '0;
        y       <= '0;
        zone    <= '0;
        in_zone <= '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
          cnt[k] <= '0;
        end
        if (state == ST_WAIT_FRAME) begin
          state <= ST_ACCUM;
        end else begin
          for (int k = 0; k < NUM_KEYS; k++) begin
            snap[k] <= cnt[k];
          end
          state <= ST_EVAL;
        end
      end else if (state != ST_WAIT_FRAME) begin
        if (state == ST_EVAL) begin
          state <= ST_ACCUM;
        end

        for (int k = 0; k < NUM_KEYS; k++) begin
          if (count_en && (zone == ZONE_W'(k)) && (cnt[k] != '1)) begin
            cnt[k] <= cnt[k] + 1'b1;
          end
        end

        // line_end wins over the x advance so a same-cycle pixel is counted
        // at its own x and the next line still starts at x=0.
        if (line_end) begin
          x       <= '0;
          zone    <= '0;
          in_zone <= '0;
          if (y != '1) begin
            y <= y + 1'b1;
          end
        end else if (pix_valid && (x != X_MAX)) begin
          x <= x + 1'b1;
          if (zone != ZONE_END) begin
            if (in_zone == IN_ZONE_LAST) begin
              in_zone <= '0;
              zone    <= zone + 1'b1;
            end else begin
              in_zone <= in_zone + 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    assign hit[k] = (snap[k] >= THRESH);

    finger_key_locator_key_debouncer #(
      .DEBOUNCE (DEBOUNCE)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .eval_en (eval_en),
      .hit     (hit[k]),
      .key_bit (key_mask[k])
    );
  end

  assign debug_out = {frame_cnt, 16'(key_mask[MW-1:0])};

endmodule
